mult_div_unit: RTL
==================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS execute stage. It takes the same register-file operands as the ALU and computes MULT, MULTU, DIV and DIVU over multiple cycles. Results go into internal HI/LO registers, which the execute-stage result mux reads for MFHI/MFLO. The hazard unit stalls the pipeline on `busy_o`; MTHI/MTLO write HI/LO directly.

## Interface
- `DATA_WIDTH`, 32: operand and HI/LO width. Only 32 is supported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start_i` in 1: request; sampled only in IDLE.
- `op_i` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start_i`.
- `a_i` in 32: rs operand (multiplicand / dividend).
- `b_i` in 32: rt operand (multiplier / divisor).
- `hi_wr_i` in 1: MTHI write enable.
- `lo_wr_i` in 1: MTLO write enable.
- `wr_data_i` in 32: MTHI/MTLO data.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `done_o` out 1: one-cycle pulse when HI/LO take a new result.
- `div_by_zero_o` out 1: one-cycle pulse, coincident with `done_o`, for DIV/DIVU with `b_i` = 0.
- `hi_o` out 32: HI register.
- `lo_o` out 32: LO register.

## Operation
- **FSM states:** IDLE, PREP, CALC, FIXUP.
  - IDLE→PREP on `start_i`; `op_i`, `a_i`, `b_i` are latched.
  - PREP→CALC; the 5-bit iteration counter is cleared.
  - CALC→FIXUP after the 32nd iteration.
  - FIXUP→IDLE.
- **PREP:**
  - Signed ops (MULT, DIV) convert both operands to magnitudes and record the signs.
  - Unsigned ops use the operands as-is.
- **Multiply:**
  - Radix-2 shift-add, one multiplier bit per CALC cycle, 64-bit accumulator.
  - FIXUP negates the 64-bit product when the signs differ.
  - {HI,LO} = product.
- **Divide:**
  - Restoring division, one quotient bit per CALC cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - LO = quotient, HI = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF wraps: LO = 0x80000000, HI = 0.
- **Divide by zero:**
  - LO = 0xFFFFFFFF, HI = `a_i` (unsigned magnitude path, no sign fixup).
  - `div_by_zero_o` pulses.
- **HI/LO writes:**
  - HI/LO change only in FIXUP or on `hi_wr_i`/`lo_wr_i`.
  - MTHI/MTLO are accepted only in IDLE and ignored while `busy_o` = 1.
  - If `start_i` and `hi_wr_i`/`lo_wr_i` arrive in the same IDLE cycle, both are accepted: the write lands immediately and the operation result later overwrites it.
- **Requests while busy:** `start_i` is ignored while busy; there is no queueing.
- **Reset:** asserting `reset` at any time, including mid-operation, forces:
  - state = IDLE;
  - `hi_o`, `lo_o`, all datapath registers = 0;
  - `busy_o`, `done_o`, `div_by_zero_o` = 0.

## Timing
- `start_i` is sampled at edge T0. Nominal schedule:
  - T1: state = PREP.
  - T2..T33: CALC iterations.
  - T34: FIXUP writes HI/LO.
- `done_o` = 1 for exactly the cycle following T34, in which HI/LO already show the result and state is IDLE.
- `busy_o` = 1 for the 34 cycles between T0 and T34.
- Back-to-back: a new `start_i` is accepted in the `done_o` cycle.
- `hi_o` and `lo_o` are register outputs with no combinational path from any input.
- MTHI/MTLO take effect on the next edge.

## Configuration
- **`MDU_EARLY_OUT_EN` defined:**
  - When the latched `b_i` = 0, PREP goes directly to FIXUP and skips CALC.
  - `done_o` then follows the edge at T2 (3-cycle latency).
  - Multiply result = 0; divide result per the divide-by-zero rule.
- **`MDU_EARLY_OUT_EN` undefined:** every operation takes the full 34-cycle path, with identical results.

## Test plan
- **MULT:** `a_i`=0xFFFFFFFD (−3), `b_i`=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; `done_o` 34 cycles after the start edge; `busy_o` high 34 cycles.
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- **DIV:** −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **DIVU:** 7 / 0 → LO=0xFFFFFFFF, HI=7, `div_by_zero_o` pulses with `done_o`.
  - With `MDU_EARLY_OUT_EN`: done 2 cycles after start.
  - Without it: 34 cycles.
- **Busy and MTHI:**
  - MULTU 3×4 started; `start_i` DIV and `hi_wr_i`=0x1234 pulsed mid-operation are both ignored.
  - Result HI=0, LO=12.
  - MTHI 0x1234 in IDLE → `hi_o`=0x1234 after the next edge.
- **Reset mid-operation:** `reset` low at cycle 10 of DIV 100/3 → `hi_o`=`lo_o`=0, `busy_o`=0 immediately, no `done_o`; a fresh DIV 100/3 after release → LO=33, HI=1.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request, MTHI/MTLO and result bus of the iterative
// multiply/divide unit.
//   master : execute stage side (drives start/op/operands and MTHI/MTLO writes)
//   slave  : mult_div_unit (drives busy/done/div_by_zero and the HI/LO registers)
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic                  hi_wr_i;
    logic                  lo_wr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  div_by_zero_o;
    logic [DATA_WIDTH-1:0] hi_o;
    logic [DATA_WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, hi_wr_i, lo_wr_i, wr_data_i,
        input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, hi_wr_i, lo_wr_i, wr_data_i,
        output busy_o, done_o, div_by_zero_o, hi_o, lo_o
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mult_div_unit_if.slave
//           start_i/op_i/a_i/b_i   request (sampled only in IDLE)
//           hi_wr_i/lo_wr_i/wr_data_i  MTHI/MTLO (accepted only in IDLE)
//           busy_o, done_o, div_by_zero_o, hi_o, lo_o
// Optional feature: define MDU_EARLY_OUT_EN to skip CALC when the divisor /
// multiplier operand b is zero (3-cycle latency instead of 35).
//
// state | meaning
// IDLE  | waiting for start_i; MTHI/MTLO accepted
// PREP  | operand magnitudes and signs, accumulator load, counter clear
// CALC  | one shift-add or restoring-divide step per cycle, 32 cycles
// FIXUP | sign fixup, HI/LO write, done pulse on the following cycle
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    mult_div_unit_if.slave  bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIXUP} state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [W-1:0]     a_q, b_q, opnd_q;
    logic [2*W-1:0]   acc_q;
    logic [4:0]       cnt_q;
    logic             neg_main_q, neg_rem_q;
    logic [W-1:0]     hi_q, lo_q;
    logic             done_q, dbz_q;

    logic             is_div, is_signed, b_zero, sign_a, sign_b;
    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_next;
    logic [W:0]       div_shift;
    logic [W-1:0]     div_rem;
    logic             div_ge;
    logic [2*W-1:0]   div_next;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quo_fix, rem_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign b_zero    = (b_q == '0);
    assign sign_a    = is_signed & a_q[W-1];
    assign sign_b    = is_signed & b_q[W-1];
    assign mag_a     = sign_a ? -a_q : a_q;
    assign mag_b     = sign_b ? -b_q : b_q;

    // Multiply: {HI,LO} starts as {0, multiplier}; add multiplicand to the
    // upper half when the current LSB is set, then shift the 65-bit sum right.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: {rem, dividend} shifts left one bit per step. The
    // shifted remainder is < 2*divisor, so the difference fits in W bits.
    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_rem   = div_shift[W-1:0] - opnd_q;
    assign div_next  = div_ge ? {div_rem, acc_q[W-2:0], 1'b1}
                              : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};

    assign prod_fix = neg_main_q ? -acc_q : acc_q;
    assign quo_fix  = neg_main_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start_i) state_nxt = PREP;
`ifdef MDU_EARLY_OUT_EN
            PREP:  state_nxt = b_zero ? FIXUP : CALC;
`else
            PREP:  state_nxt = CALC;
`endif
            CALC:  if (cnt_q == 5'd31) state_nxt = FIXUP;
            FIXUP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_wr_i) hi_q <= bus.wr_data_i;
                    if (bus.lo_wr_i) lo_q <= bus.wr_data_i;
                    if (bus.start_i) begin
                        op_q <= bus.op_i;
                        a_q  <= bus.a_i;
                        b_q  <= bus.b_i;
                    end
                end
                PREP: begin
                    neg_main_q <= sign_a ^ sign_b;
                    neg_rem_q  <= sign_a;
                    cnt_q      <= '0;
                    if (is_div) begin
                        opnd_q <= mag_b;
                        acc_q  <= {{W{1'b0}}, mag_a};
                    end else begin
                        opnd_q <= mag_a;
                        acc_q  <= {{W{1'b0}}, mag_b};
                    end
                end
                CALC: begin
                    acc_q <= is_div ? div_next : mul_next;
                    cnt_q <= cnt_q + 5'd1;
                end
                FIXUP: begin
                    done_q <= 1'b1;
                    if (is_div && b_zero) begin
                        // Raw dividend, no sign fixup, regardless of signedness.
                        hi_q  <= a_q;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o        = (state != IDLE);
    assign bus.done_o        = done_q;
    assign bus.div_by_zero_o = dbz_q;
    assign bus.hi_o          = hi_q;
    assign bus.lo_o          = lo_q;
endmodule
